// File: rtl/disp_pkg.sv
// Shared types and constants for the scrolling seven-segment message sequencer.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int         CHAR_W    = 4;
  localparam logic [3:0] BLANK_ALL = 4'b1111;

  // Address width for a message buffer of msg_len entries.
  function automatic int idx_w(input int msg_len);
    return (msg_len > 1) ? $clog2(msg_len) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Scroll-step divider: counts enabled cycles and wraps at TICK_DIV-1.
// o_tick flags the terminal count; the wrap happens on the next enabled edge.
module tick_divider #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Divider counter; clear takes priority over enable.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en) begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/display_scroll_ctrl.sv
// Feeds a four-digit seven-segment driver with a four-character window that
// scrolls through a small character buffer, one position per divided tick.
module display_scroll_ctrl
  import disp_pkg::*;
#(
  parameter int MSG_LEN  = 16,
  parameter int TICK_DIV = 12_500_000,
  parameter int CHAR_W   = disp_pkg::CHAR_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [idx_w(MSG_LEN)-1:0]   i_wr_addr,
  input  logic [CHAR_W-1:0]           i_wr_data,
  input  logic                        i_start,
  input  logic                        i_loop,
  input  logic                        i_pause,
  input  logic                        i_stop,
  output logic [4*CHAR_W-1:0]         o_digits,
  output logic [3:0]                  o_blank,
  output logic                        o_busy,
  output logic                        o_step,
  output logic                        o_done,
  output logic                        o_wr_err
);

  localparam int            AW      = idx_w(MSG_LEN);
  localparam logic [AW-1:0] POS_MAX = AW'(MSG_LEN - 1);
  localparam int            DW      = 4 * CHAR_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_pos;
  logic [AW-1:0]     w_pos_nxt;
  logic              r_loop;
  logic              w_loop_nxt;
  logic              w_step_nxt;
  logic              w_done_nxt;
  logic              w_busy_nxt;
  logic              w_cnt_en;
  logic              w_cnt_clr;
  logic              w_tick;
  logic [CHAR_W-1:0] r_buf [MSG_LEN];
  logic [DW-1:0]     w_window;
  logic [DW-1:0]     r_digits;
  logic [3:0]        r_blank;
  logic              r_busy;
  logic              r_step;
  logic              r_done;
  logic              r_wr_err;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_cnt_en),
    .i_clr  (w_cnt_clr),
    .o_tick (w_tick)
  );

  // Counter control: a pending advance beats pause, so HOLD never sits on the terminal count.
  always_comb begin
    w_cnt_clr = (r_state == ST_IDLE) || i_stop;
    w_cnt_en  = 1'b0;
    case (r_state)
      ST_RUN:  w_cnt_en = !i_pause || w_tick;
      ST_HOLD: w_cnt_en = !i_pause;
      default: w_cnt_en = 1'b0;
    endcase
  end

  // Next-state logic: stop > tick advance > pause > start.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_loop_nxt  = r_loop;
    w_step_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (i_start) begin
          w_state_nxt = ST_RUN;
          w_pos_nxt   = {AW{1'b0}};
          w_loop_nxt  = i_loop;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
          w_pos_nxt   = {AW{1'b0}};
        end else if (w_tick) begin
          w_step_nxt = 1'b1;
          if (r_pos == POS_MAX) begin
            w_pos_nxt = {AW{1'b0}};
            if (r_loop) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_pos_nxt = r_pos + AW'(1);
          end
        end else if (i_pause) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
          w_pos_nxt   = {AW{1'b0}};
        end else if (!i_pause) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pos_nxt   = {AW{1'b0}};
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != ST_IDLE);

  // Window mux for the upcoming position; digit3 (top slice) shows buf[pos].
  always_comb begin
    w_window = {DW{1'b0}};
    for (int k = 0; k < 4; k++) begin
      w_window[k*CHAR_W +: CHAR_W] = r_buf[w_pos_nxt + AW'(3 - k)];
    end
  end

  // Message buffer; writes land only while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_buf[i] <= {CHAR_W{1'b0}};
      end
    end else if (i_wr_en && (r_state == ST_IDLE)) begin
      r_buf[i_wr_addr] <= i_wr_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_pos    <= {AW{1'b0}};
      r_loop   <= 1'b0;
      r_digits <= {DW{1'b0}};
      r_blank  <= BLANK_ALL;
      r_busy   <= 1'b0;
      r_step   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pos    <= w_pos_nxt;
      r_loop   <= w_loop_nxt;
      r_digits <= w_busy_nxt ? w_window : {DW{1'b0}};
      r_blank  <= w_busy_nxt ? 4'b0000 : BLANK_ALL;
      r_busy   <= w_busy_nxt;
      r_step   <= w_step_nxt;
      r_done   <= w_done_nxt;
      r_wr_err <= i_wr_en && (r_state != ST_IDLE);
    end
  end

  assign o_digits = r_digits;
  assign o_blank  = r_blank;
  assign o_busy   = r_busy;
  assign o_step   = r_step;
  assign o_done   = r_done;
  assign o_wr_err = r_wr_err;

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus, every cycle
// compared against a cycle-level reference model of the scroller.
module tb_display_scroll_ctrl;

  localparam int MSG_LEN  = 16;
  localparam int TICK_DIV = 4;
  localparam int CHAR_W   = 4;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        start;
  logic        loop;
  logic        pause;
  logic        stop;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        busy;
  logic        step;
  logic        done;
  logic        wr_err;

  int n_checks;
  int n_errors;

  // reference model state
  int m_buf [MSG_LEN];
  bit m_active;
  int m_pos;
  int m_elapsed;
  bit m_loop;
  bit e_step;
  bit e_done;
  bit e_wr_err;

  display_scroll_ctrl #(
    .MSG_LEN  (MSG_LEN),
    .TICK_DIV (TICK_DIV),
    .CHAR_W   (CHAR_W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_start   (start),
    .i_loop    (loop),
    .i_pause   (pause),
    .i_stop    (stop),
    .o_digits  (digits),
    .o_blank   (blank),
    .o_busy    (busy),
    .o_step    (step),
    .o_done    (done),
    .o_wr_err  (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Window as four hex characters, leftmost digit = buf[pos].
  function automatic int exp_digits();
    int acc;
    acc = 0;
    if (m_active) begin
      for (int k = 0; k < 4; k++) begin
        acc = acc * 16 + m_buf[(m_pos + k) % MSG_LEN];
      end
    end
    return acc;
  endfunction

  // One clock edge of the behavioural model, using the inputs held at that edge.
  task automatic model_update();
    e_step   = 1'b0;
    e_done   = 1'b0;
    e_wr_err = 1'b0;
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 0;
      m_active  = 1'b0;
      m_pos     = 0;
      m_elapsed = 0;
      m_loop    = 1'b0;
    end else if (!m_active) begin
      if (wr_en) m_buf[wr_addr] = wr_data;
      if (start && !stop) begin
        m_active  = 1'b1;
        m_pos     = 0;
        m_elapsed = 0;
        m_loop    = loop;
      end
    end else begin
      if (wr_en) e_wr_err = 1'b1;
      if (stop) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else if (m_elapsed == TICK_DIV - 1) begin
        m_elapsed = 0;
        e_step    = 1'b1;
        if (m_pos == MSG_LEN - 1) begin
          m_pos = 0;
          if (!m_loop) begin
            m_active = 1'b0;
            e_done   = 1'b1;
          end
        end else begin
          m_pos = m_pos + 1;
        end
      end else if (!pause) begin
        m_elapsed = m_elapsed + 1;
      end
    end
  endtask

  task automatic compare_all();
    check_val("digits", 32'(digits), 32'(exp_digits()));
    check_val("blank",  32'(blank),  m_active ? 32'h0 : 32'hF);
    check_val("busy",   32'(busy),   32'(m_active));
    check_val("step",   32'(step),   32'(e_step));
    check_val("done",   32'(done),   32'(e_done));
    check_val("wr_err", 32'(wr_err), 32'(e_wr_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic do_start(input logic lp);
    start = 1'b1;
    loop  = lp;
    tick();
    start = 1'b0;
    loop  = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
    start = 1'b0; loop = 1'b0; pause = 1'b0; stop = 1'b0;
    for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 0;
    m_active = 1'b0; m_pos = 0; m_elapsed = 0; m_loop = 1'b0;

    // reset state, then idle with no steps
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_digits", 32'(digits), 32'h0);
    check_val("rst_blank",  32'(blank),  32'hF);
    check_val("rst_busy",   32'(busy),   32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("idle_step", 32'(step), 32'h0);
    end

    // one-shot pass over buf[i]=i
    for (int i = 0; i < MSG_LEN; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(i);
      tick();
    end
    wr_en = 1'b0;
    do_start(1'b0);
    check_val("t1_win0", 32'(digits), 32'h0123);
    check_val("t1_busy", 32'(busy), 32'h1);
    for (int c = 2; c <= 65; c++) begin
      tick();
      if (c == 5) begin
        check_val("t1_step1_digits", 32'(digits), 32'h1234);
        check_val("t1_step1_pulse",  32'(step),   32'h1);
      end
      if (c == 53) check_val("t1_pos13", 32'(digits), 32'hDEF0);
      if (c == 65) begin
        check_val("t1_done",  32'(done),  32'h1);
        check_val("t1_blank", 32'(blank), 32'hF);
        check_val("t1_busy0", 32'(busy),  32'h0);
      end
    end

    // looping pass returns to the start
    do_start(1'b1);
    for (int c = 2; c <= 65; c++) tick();
    check_val("t2_wrap", 32'(digits), 32'h0123);
    check_val("t2_busy", 32'(busy),   32'h1);
    check_val("t2_done", 32'(done),   32'h0);
    do_stop();

    // pause for 7 cycles mid-interval delays the next step by 7
    do_start(1'b1);
    tick();
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_val("t3_hold_digits", 32'(digits), 32'h0123);
    end
    pause = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (step) break;
    end
    check_val("t3_step_seen",  32'(step), 32'h1);
    check_val("t3_pause_delay", 32'(n),   32'd3);
    do_stop();

    // write while running is dropped
    do_start(1'b1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'hF;
    tick();
    wr_en = 1'b0;
    check_val("t4_wr_err", 32'(wr_err), 32'h1);
    do_stop();
    do_start(1'b0);
    check_val("t4_buf_kept", 32'(digits), 32'h0123);
    do_stop();

    // stop on the advancing edge
    do_start(1'b0);
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("t5_step",   32'(step),   32'h0);
    check_val("t5_done",   32'(done),   32'h0);
    check_val("t5_busy",   32'(busy),   32'h0);
    check_val("t5_digits", 32'(digits), 32'h0);

    // reset while held
    do_start(1'b1);
    tick();
    pause = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    check_val("t6_busy",   32'(busy),   32'h0);
    check_val("t6_blank",  32'(blank),  32'hF);
    check_val("t6_digits", 32'(digits), 32'h0);
    rst = 1'b0; pause = 1'b0;
    tick();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 399) == 0);
      stop    = ($urandom_range(0, 149) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      start   = !wr_en && ($urandom_range(0, 5) == 0);
      loop    = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) pause = !pause;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
